hazard_control_unit: RTL and testbench

- Parametrised successor to the single-cycle load-use detector: one pipeline hazard controller for the 5-stage RV32 core, sitting between the decoder (ID) and the DEC_ALU/EX stage.
- Handles three hazards, each with a stall length set by a parameter:
  - load-use stalls of configurable length,
  - multi-cycle mul/div occupancy of EX, with early completion,
  - taken-branch flush.
- Also keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_control_unit_pkg.sv | 11 +
 rtl/hazard_control_unit_load_use.sv | 24 ++
 rtl/hazard_control_unit.sv | 121 ++++++++++++
 tb/tb_hazard_control_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_control_unit_pkg.sv
// Shared constants and FSM encodings for the hazard controller.
package hazard_control_unit_pkg;
    localparam int         REG_ADDR_SIZE = 5;
    localparam logic [6:0] OPCODE_I_LOAD = 7'b0000011;

    typedef enum logic [1:0] {
        HZ_RUN       = 2'd0,
        HZ_LOAD_WAIT = 2'd1,
        HZ_MD_BUSY   = 2'd2
    } hz_state_e;
endpackage

// File: rtl/hazard_control_unit_load_use.sv
// Combinational load-use detector, shared with the forwarding unit.
module load_use_compare
    import hazard_control_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int OPCODE_W   = 7
) (
    input  logic [OPCODE_W-1:0]   op_ex,
    input  logic [REG_ADDR_W-1:0] rd_ex,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic                  rs1_used,
    input  logic                  rs2_used,
    output logic                  load_haz
);
    logic is_load;
    logic hit1;
    logic hit2;

    assign is_load  = (op_ex == OPCODE_W'(OPCODE_I_LOAD));
    assign hit1     = rs1_used && (rs1_id == rd_ex);
    assign hit2     = rs2_used && (rs2_id == rd_ex);
    assign load_haz = is_load && (rd_ex != '0) && (hit1 || hit2);
endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use, mul/div occupancy, branch flush.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int OPCODE_W   = 7,
    parameter int LOAD_LAT   = 1,
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OPCODE_W-1:0]   opCodeFromDec,
    input  logic [REG_ADDR_W-1:0] writeBackAddr,
    input  logic [REG_ADDR_W-1:0] source1,
    input  logic [REG_ADDR_W-1:0] source2,
    input  logic                  src1Used,
    input  logic                  src2Used,
    input  logic                  mdStart,
    input  logic                  mdDone,
    input  logic                  branchTaken,
    output logic                  PCLocker,
    output logic                  IF_IDLocker,
    output logic                  ifIdFlush,
    output logic                  idExBubble,
    output logic                  exHold,
    output logic [CNT_W-1:0]      stallCycles
);
    localparam int MAX_LAT = (LOAD_LAT > MULDIV_LAT) ? LOAD_LAT : MULDIV_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;
    localparam int LD_I    = (LOAD_LAT > 1) ? LOAD_LAT - 2 : 0;
    localparam int MD_I    = (MULDIV_LAT > 1) ? MULDIV_LAT - 2 : 0;
    localparam logic [CW-1:0] LD_INIT = CW'(LD_I);
    localparam logic [CW-1:0] MD_INIT = CW'(MD_I);

    hz_state_e      state_q;
    hz_state_e      state_d;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic           load_haz;

    load_use_compare #(
        .REG_ADDR_W (REG_ADDR_W),
        .OPCODE_W   (OPCODE_W)
    ) u_cmp (
        .op_ex    (opCodeFromDec),
        .rd_ex    (writeBackAddr),
        .rs1_id   (source1),
        .rs2_id   (source2),
        .rs1_used (src1Used),
        .rs2_used (src2Used),
        .load_haz (load_haz)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HZ_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        PCLocker    = 1'b1;
        IF_IDLocker = 1'b1;
        ifIdFlush   = 1'b0;
        idExBubble  = 1'b0;
        exHold      = 1'b0;
        case (state_q)
            HZ_RUN: begin
                // ID instruction is squashed by a taken branch, so its hazard is moot
                if (branchTaken) begin
                    ifIdFlush  = 1'b1;
                    idExBubble = 1'b1;
                end else if (mdStart && (MULDIV_LAT > 1)) begin
                    if (!mdDone) begin
                        PCLocker    = 1'b0;
                        IF_IDLocker = 1'b0;
                        exHold      = 1'b1;
                        state_d     = HZ_MD_BUSY;
                        cnt_d       = MD_INIT;
                    end
                end else if (load_haz) begin
                    PCLocker    = 1'b0;
                    IF_IDLocker = 1'b0;
                    idExBubble  = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = HZ_LOAD_WAIT;
                        cnt_d   = LD_INIT;
                    end
                end
            end
            HZ_LOAD_WAIT: begin
                PCLocker    = 1'b0;
                IF_IDLocker = 1'b0;
                idExBubble  = 1'b1;
                if (cnt_q == '0) state_d = HZ_RUN;
                else             cnt_d   = cnt_q - 1'b1;
            end
            HZ_MD_BUSY: begin
                PCLocker    = 1'b0;
                IF_IDLocker = 1'b0;
                exHold      = 1'b1;
                if (mdDone || cnt_q == '0) state_d = HZ_RUN;
                else                       cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = HZ_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stallCycles <= '0;
        else if (!PCLocker && stallCycles != {CNT_W{1'b1}})
            stallCycles <= stallCycles + 1'b1;
    end
endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit over three parameter sets.
module tb_hazard_control_unit;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ADD = 7'b0110011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2, ms, md, br;

    logic pc_a, ifid_a, fl_a, bub_a, hold_a;
    logic pc_b, ifid_b, fl_b, bub_b, hold_b;
    logic pc_c, ifid_c, fl_c, bub_c, hold_c;
    logic [15:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [6:0] op;
        logic [4:0] rd, rs1, rs2;
        logic       u1, u2, ms, md, br;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[10];

    always #5 clk = ~clk;

    hazard_control_unit #(.LOAD_LAT(1), .MULDIV_LAT(4), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .opCodeFromDec(op), .writeBackAddr(rd),
        .source1(rs1), .source2(rs2), .src1Used(u1), .src2Used(u2),
        .mdStart(ms), .mdDone(md), .branchTaken(br),
        .PCLocker(pc_a), .IF_IDLocker(ifid_a), .ifIdFlush(fl_a),
        .idExBubble(bub_a), .exHold(hold_a), .stallCycles(cnt_a));

    hazard_control_unit #(.LOAD_LAT(3), .MULDIV_LAT(4), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .opCodeFromDec(op), .writeBackAddr(rd),
        .source1(rs1), .source2(rs2), .src1Used(u1), .src2Used(u2),
        .mdStart(ms), .mdDone(md), .branchTaken(br),
        .PCLocker(pc_b), .IF_IDLocker(ifid_b), .ifIdFlush(fl_b),
        .idExBubble(bub_b), .exHold(hold_b), .stallCycles(cnt_b));

    hazard_control_unit #(.LOAD_LAT(1), .MULDIV_LAT(1), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .opCodeFromDec(op), .writeBackAddr(rd),
        .source1(rs1), .source2(rs2), .src1Used(u1), .src2Used(u2),
        .mdStart(ms), .mdDone(md), .branchTaken(br),
        .PCLocker(pc_c), .IF_IDLocker(ifid_c), .ifIdFlush(fl_c),
        .idExBubble(bub_c), .exHold(hold_c), .stallCycles(cnt_c));

    // exHold without a fresh mdStart means MD_BUSY; a branch there is illegal
    always @(posedge clk) begin
        if (!rst)
            assert (!(hold_a && !ms && br))
                else $error("branchTaken during MD_BUSY");
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] outs_a();
        return {pc_a, ifid_a, fl_a, bub_a, hold_a};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] o, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2,
                         input logic a1, input logic a2, input logic m,
                         input logic dn, input logic b);
        op = o; rd = d; rs1 = s1; rs2 = s2;
        u1 = a1; u2 = a2; ms = m; md = dn; br = b;
    endtask

    task automatic idle();
        drive(OP_ADD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic hazard();
        drive(OP_LD, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // expected = {PCLocker, IF_IDLocker, ifIdFlush, idExBubble, exHold}
        tbl[0] = '{OP_ADD, 5'd5, 5'd5, 5'd5, 1, 0, 0, 0, 0, 5'b11000};
        tbl[1] = '{OP_LD,  5'd5, 5'd5, 5'd0, 1, 0, 0, 0, 0, 5'b00010};
        tbl[2] = '{OP_LD,  5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0, 5'b11000};
        tbl[3] = '{OP_LD,  5'd5, 5'd3, 5'd5, 1, 0, 0, 0, 0, 5'b11000};
        tbl[4] = '{OP_LD,  5'd5, 5'd3, 5'd5, 1, 1, 0, 0, 0, 5'b00010};
        tbl[5] = '{OP_LD,  5'd7, 5'd7, 5'd7, 0, 0, 0, 0, 0, 5'b11000};
        tbl[6] = '{OP_LD,  5'd5, 5'd5, 5'd0, 1, 0, 0, 0, 1, 5'b11110};
        tbl[7] = '{OP_ADD, 5'd5, 5'd5, 5'd0, 1, 0, 1, 1, 0, 5'b11000};
        tbl[8] = '{OP_ADD, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b11110};
        tbl[9] = '{OP_LD,  5'd5, 5'd6, 5'd4, 1, 1, 0, 0, 0, 5'b11000};

        idle();
        #1;
        chk("reset outs", 32'(outs_a()), 32'b11000);
        chk("reset cnt", 32'(cnt_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].u1,
                  tbl[i].u2, tbl[i].ms, tbl[i].md, tbl[i].br);
            #1;
            chk($sformatf("vec%0d", i), 32'(outs_a()), 32'(tbl[i].exp));
        end
        @(negedge clk);
        idle();
        #1;
        chk("table cnt", 32'(cnt_a), 32'd2);

        do_reset();
        @(negedge clk); hazard(); #1;
        chk("ld1 c1", 32'(outs_a()), 32'b00010);
        @(negedge clk); idle(); #1;
        chk("ld1 c2", 32'(outs_a()), 32'b11000);
        chk("ld1 cnt", 32'(cnt_a), 32'd1);

        do_reset();
        @(negedge clk); hazard(); #1;
        chk("ld3 c1", 32'({pc_b, ifid_b, fl_b, bub_b, hold_b}), 32'b00010);
        for (int i = 2; i <= 3; i++) begin
            @(negedge clk); idle(); #1;
            chk($sformatf("ld3 c%0d", i),
                32'({pc_b, ifid_b, fl_b, bub_b, hold_b}), 32'b00010);
        end
        @(negedge clk); #1;
        chk("ld3 c4", 32'({pc_b, ifid_b, fl_b, bub_b, hold_b}), 32'b11000);
        chk("ld3 cnt", 32'(cnt_b), 32'd3);

        do_reset();
        @(negedge clk);
        drive(OP_ADD, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("md c1", 32'(outs_a()), 32'b00001);
        chk("md lat1", 32'({pc_c, ifid_c, fl_c, bub_c, hold_c}), 32'b11000);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk); idle(); #1;
            chk($sformatf("md c%0d", i), 32'(outs_a()), 32'b00001);
        end
        @(negedge clk); #1;
        chk("md c5", 32'(outs_a()), 32'b11000);
        chk("md cnt", 32'(cnt_a), 32'd4);

        do_reset();
        @(negedge clk);
        drive(OP_ADD, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("mdd c1", 32'(outs_a()), 32'b00001);
        @(negedge clk);
        drive(OP_ADD, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("mdd c2", 32'(outs_a()), 32'b00001);
        @(negedge clk); idle(); #1;
        chk("mdd c3", 32'(outs_a()), 32'b11000);
        chk("mdd cnt", 32'(cnt_a), 32'd2);

        do_reset();
        @(negedge clk);
        drive(OP_ADD, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); idle(); #1;
        chk("rst busy", 32'(outs_a()), 32'b00001);
        rst = 1'b1;
        #1;
        chk("rst async outs", 32'(outs_a()), 32'b11000);
        chk("rst async cnt", 32'(cnt_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst after", 32'(outs_a()), 32'b11000);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); hazard(); #1;
            if (i == 14) chk("sat mid", 32'(cnt_c), 32'd14);
        end
        @(negedge clk); idle(); #1;
        chk("sat cnt_c", 32'(cnt_c), 32'd15);
        chk("sat cnt_a", 32'(cnt_a), 32'd20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
